// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache
//   Direct-mapped, write-through, no-write-allocate data cache for the MEM
//   stage. One 32-bit word per line. A load that hits completes in the same
//   cycle. A load miss refills from main memory. Every store is written
//   through to memory. While an access is in flight, hit is held low so the
//   pipeline stalls.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   MemRead, MemWrite   access request (a store wins when both are high)
//   address, writeData  byte address (low two bits ignored), store data
//   hit, readData       advance qualifier and load data to MEM/WB
//   mem_*               req/ack main-memory port (ack is a one-cycle strobe)
//   rd_hits, rd_misses  saturating read performance counters
module mem_stage_dcache #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      address,
    input  logic [31:0]      writeData,
    output logic             hit,
    output logic [31:0]      readData,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] rd_hits,
    output logic [CNT_W-1:0] rd_misses
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRTHRU, DONE} state_e;

    state_e                        state_q, state_d;
    logic [LINES-1:0]              valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [LINES-1:0][31:0]        data_q, data_d;
    logic [29:0]                   addr_q, addr_d;   // word address of the latched access
    logic [31:0]                   wdata_q, wdata_d;
    logic [31:0]                   fill_q, fill_d;
    logic                          rd_op_q, rd_op_d; // latched access was a load
    logic [CNT_W-1:0]              hits_q, hits_d, misses_q, misses_d;

    logic [INDEX_BITS-1:0] idx, lat_idx;
    logic [TAG_W-1:0]      tg;
    logic                  lookup_hit, hit_c;
    logic [31:0]           rdata_c;
    logic                  unused_addr_bits;

    assign idx        = address[INDEX_BITS+1:2];
    assign tg         = address[31:INDEX_BITS+2];
    assign lat_idx    = addr_q[INDEX_BITS-1:0];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tg);
    assign unused_addr_bits = ^address[1:0];

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fill_d   = fill_q;
        rd_op_d  = rd_op_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        hit_c    = 1'b0;
        rdata_c  = '0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    addr_d  = address[31:2];
                    wdata_d = writeData;
                    rd_op_d = 1'b0;
                    state_d = WRTHRU;
                    // Keep a resident copy coherent; misses do not allocate.
                    if (lookup_hit) data_d[idx] = writeData;
                end else if (MemRead) begin
                    if (lookup_hit) begin
                        hit_c   = 1'b1;
                        rdata_c = data_q[idx];
                        if (hits_q != '1) hits_d = hits_q + 1'b1;
                    end else begin
                        addr_d  = address[31:2];
                        rd_op_d = 1'b1;
                        state_d = REFILL;
                        if (misses_q != '1) misses_d = misses_q + 1'b1;
                    end
                end else begin
                    hit_c = 1'b1;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    valid_d[lat_idx] = 1'b1;
                    tag_d[lat_idx]   = addr_q[29:INDEX_BITS];
                    data_d[lat_idx]  = mem_rdata;
                    fill_d           = mem_rdata;
                    state_d          = DONE;
                end
            end
            WRTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_d = DONE;
            end
            DONE: begin
                // One-cycle completion pulse; the pipeline advances on its negedge.
                hit_c   = 1'b1;
                rdata_c = rd_op_q ? fill_q : 32'h0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // hit must read 1 while reset is held, regardless of the request inputs.
    assign hit       = hit_c | ~RST_N;
    assign readData  = RST_N ? rdata_c : 32'h0;
    assign mem_addr  = mem_req ? {addr_q, 2'b00} : 32'h0;
    assign mem_wdata = mem_we ? wdata_q : 32'h0;
    assign rd_hits   = hits_q;
    assign rd_misses = misses_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fill_q   <= '0;
            rd_op_q  <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fill_q   <= fill_d;
            rd_op_q  <= rd_op_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end
endmodule
